// File: rtl/wb_conbus_rr.sv
// Wishbone shared-bus interconnect for the LM32 SoC.
// N_M masters share one bus through a round-robin arbiter. The granted
// master's top address bits select one of N_S slaves. An unmapped address
// gets an error response, and a per-transfer watchdog raises an error when
// a slave never acks. Errors also pulse bus_err and capture err_adr.
module wb_conbus_rr #(
    parameter int                      N_M      = 2,
    parameter int                      N_S      = 7,
    parameter int                      S_ADDR_W = 3,
    parameter logic [S_ADDR_W*N_S-1:0] S_ADDR   = 21'b111_110_101_100_011_010_000,
    parameter int                      TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    // master side
    input  logic [32*N_M-1:0]   m_dat_i,
    input  logic [32*N_M-1:0]   m_adr_i,
    input  logic [4*N_M-1:0]    m_sel_i,
    input  logic [N_M-1:0]      m_we_i,
    input  logic [N_M-1:0]      m_cyc_i,
    input  logic [N_M-1:0]      m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic [N_M-1:0]      m_ack_o,
    output logic [N_M-1:0]      m_err_o,
    // slave side
    input  logic [32*N_S-1:0]   s_dat_i,
    input  logic [N_S-1:0]      s_ack_i,
    output logic [31:0]         s_dat_o,
    output logic [31:0]         s_adr_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic [N_S-1:0]      s_cyc_o,
    output logic [N_S-1:0]      s_stb_o,
    // error reporting
    output logic                bus_err,
    output logic [31:0]         err_adr
);

    localparam int            GW     = (N_M > 1) ? $clog2(N_M) : 1;
    localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);
    localparam bit            TMO_EN = (TIMEOUT > 0);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state, next_state;
    logic [GW-1:0] gnt, next_gnt;
    logic [GW-1:0] last_gnt, next_last;

    // granted-master view of the bus
    logic          g_cyc, g_stb, g_we;
    logic [31:0]   g_adr, g_dat;
    logic [3:0]    g_sel;

    // decode and response
    logic [N_S-1:0] sel_oh;
    logic           hit;
    logic           sel_ack;
    logic [31:0]    sel_dat;

    // error machinery
    logic [CW-1:0]  cnt;
    logic           tmo_err;
    logic           dec_req, dec_err_q, dec_done;
    logic           err_any;

    // Arbiter state register: grant owner and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= GW'(N_M - 1);
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the block order.
            state    <= next_state;
            gnt      <= next_gnt;
            last_gnt <= next_last;
        end
    end

    // Next-state logic: rotating scan from last_grant+1 while idle; hold while owner keeps cyc.
    always_comb begin
        int  pos;
        logic found;
        logic [GW-1:0] pick;
        // NOTE: every output of a combinational block gets a default up front,
        // otherwise paths that skip an assignment infer a latch.
        next_state = state;
        next_gnt   = gnt;
        next_last  = last_gnt;
        pick       = last_gnt;
        found      = 1'b0;
        pos        = 0;
        for (int k = 1; k <= N_M; k++) begin
            pos = int'(last_gnt) + k;
            if (pos >= N_M) pos = pos - N_M;
            for (int j = 0; j < N_M; j++) begin
                if (!found && (j == pos) && m_cyc_i[j]) begin
                    found = 1'b1;
                    pick  = GW'(j);
                end
            end
        end
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = BUSY;
                    next_gnt   = pick;
                    next_last  = pick;
                end
            end
            BUSY: begin
                if (!g_cyc) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Granted master mux; everything reads zero while nobody owns the bus.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int j = 0; j < N_M; j++) begin
            if (state == BUSY && gnt == GW'(j)) begin
                g_cyc = m_cyc_i[j];
                g_stb = m_cyc_i[j] & m_stb_i[j];
                g_we  = m_we_i[j];
                g_adr = m_adr_i[32*j +: 32];
                g_dat = m_dat_i[32*j +: 32];
                g_sel = m_sel_i[4*j +: 4];
            end
        end
    end

    // Address decode: lowest-index slave wins when decode values collide.
    always_comb begin
        sel_oh = '0;
        hit    = 1'b0;
        for (int i = 0; i < N_S; i++) begin
            if (g_cyc && !hit &&
                g_adr[31 -: S_ADDR_W] == S_ADDR[S_ADDR_W*i +: S_ADDR_W]) begin
                sel_oh[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    // Response path from the selected slave; unselected acks are dropped.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N_S; i++) begin
            if (sel_oh[i]) sel_dat = s_dat_i[32*i +: 32];
        end
        sel_ack = |(s_ack_i & sel_oh);
    end

    // The watchdog fires only when the count is exhausted and the slave is not
    // acking right now, so a last-moment ack always beats the error. This makes
    // the masked strobe depend on s_ack_i for that one cycle only.
    assign tmo_err = TMO_EN && g_stb && hit && !sel_ack && (cnt == T_MAX);
    assign dec_req = g_stb && !hit && !dec_done;
    assign err_any = tmo_err || (dec_err_q && state == BUSY);

    // Error bookkeeping: watchdog count, one-shot decode error, captured address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            dec_err_q <= 1'b0;
            dec_done  <= 1'b0;
            err_adr   <= '0;
        end else begin
            if (!g_stb || !hit || sel_ack || tmo_err) begin
                cnt <= '0;
            end else if (cnt != T_MAX) begin
                cnt <= cnt + 1'b1;
            end
            dec_err_q <= dec_req;
            dec_done  <= g_stb && (dec_done || dec_req);
            if (err_any) err_adr <= g_adr;
        end
    end

    // Output logic: per-slave strobes, per-master responses, broadcasts.
    always_comb begin
        s_cyc_o = sel_oh;
        s_stb_o = {N_S{g_stb && !tmo_err}} & sel_oh;
        s_dat_o = g_dat;
        s_adr_o = g_adr;
        s_sel_o = g_sel;
        s_we_o  = g_we;
        m_dat_o = sel_dat;
        m_ack_o = '0;
        m_err_o = '0;
        for (int j = 0; j < N_M; j++) begin
            if (state == BUSY && gnt == GW'(j)) begin
                m_ack_o[j] = sel_ack;
                m_err_o[j] = err_any;
            end
        end
        bus_err = err_any;
    end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Self-checking bench for wb_conbus_rr: directed and randomized transfers
// compared against a small behavioural model (address table decode and a
// round-robin pick over the request vector). Two instances share stimulus:
// one with an 8-cycle watchdog, one with the watchdog disabled.
module tb_wb_conbus_rr;

    localparam int N_M = 2;
    localparam int N_S = 7;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   m_dat_i, m_adr_i;
    logic [7:0]    m_sel_i;
    logic [1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [223:0]  s_dat_i;
    logic [6:0]    s_ack_i;

    logic [31:0]   m_dat_o, s_dat_o, s_adr_o, err_adr;
    logic [1:0]    m_ack_o, m_err_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, bus_err;
    logic [6:0]    s_cyc_o, s_stb_o;

    logic [31:0]   nt_m_dat_o, nt_s_dat_o, nt_s_adr_o, nt_err_adr;
    logic [1:0]    nt_m_ack_o, nt_m_err_o;
    logic [3:0]    nt_s_sel_o;
    logic          nt_s_we_o, nt_bus_err;
    logic [6:0]    nt_s_cyc_o, nt_s_stb_o;

    int n_cmp = 0;
    int n_bad = 0;
    int model_last = N_M - 1;
    int slave_code [N_S] = '{0, 2, 3, 4, 5, 6, 7};

    always #5 clk = ~clk;

    wb_conbus_rr #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .bus_err(bus_err), .err_adr(err_adr)
    );

    wb_conbus_rr #(.TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst),
        .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(nt_m_dat_o), .m_ack_o(nt_m_ack_o), .m_err_o(nt_m_err_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_dat_o(nt_s_dat_o), .s_adr_o(nt_s_adr_o), .s_sel_o(nt_s_sel_o), .s_we_o(nt_s_we_o),
        .s_cyc_o(nt_s_cyc_o), .s_stb_o(nt_s_stb_o),
        .bus_err(nt_bus_err), .err_adr(nt_err_adr)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave whose decode value equals the top three address bits, lowest index first.
    function automatic int ref_decode(input logic [31:0] adr);
        for (int i = 0; i < N_S; i++) begin
            if (int'(adr[31:29]) == slave_code[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [6:0] slave_oh(input int s);
        logic [6:0] one;
        one = 7'd1;
        return (s < 0) ? 7'd0 : (one << s);
    endfunction

    // First requester after the previous owner, wrapping around.
    function automatic int rr_pick(input int last, input logic [1:0] req);
        for (int k = 1; k <= N_M; k++) begin
            if (req[(last + k) % N_M]) return (last + k) % N_M;
        end
        return -1;
    endfunction

    // One transfer from a lone master; the selected slave acks on stb cycle 'lat'.
    task automatic run_xfer(input int m, input logic [31:0] adr, input int lat,
                            input bit noise, input logic [31:0] rd);
        int          es;
        logic [6:0]  oh;
        logic [31:0] wdat;
        logic [3:0]  wsel;
        logic        we;
        logic [1:0]  mbit;
        es   = ref_decode(adr);
        oh   = slave_oh(es);
        wdat = $urandom;
        wsel = 4'($urandom);
        we   = 1'($urandom);
        mbit = 2'd1 << m;
        @(negedge clk);
        m_adr_i[32*m +: 32] = adr;
        m_dat_i[32*m +: 32] = wdat;
        m_sel_i[4*m +: 4]   = wsel;
        m_we_i[m]  = we;
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
        model_last = m;
        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_S; i++) s_dat_i[32*i +: 32] = $urandom;
            s_ack_i = noise ? (7'($urandom) & ~oh) : 7'd0;
            if (es >= 0 && c == lat) begin
                s_ack_i = s_ack_i | oh;
                s_dat_i[32*es +: 32] = rd;
            end
            #1;
            if (c == 1) begin
                check("grant_cyc", s_cyc_o, oh);
                check("bcast", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, {adr, wdat, wsel, we});
            end
            if (es >= 0) begin
                check("slave_stb", s_stb_o, oh);
                check("ack", m_ack_o, (c == lat) ? mbit : 2'b00);
                check("no_err", {m_err_o, bus_err}, 3'b000);
                if (c == lat) begin
                    check("rdata", m_dat_o, rd);
                    break;
                end
            end else begin
                check("miss_stb", s_stb_o, 7'd0);
                check("miss_ack", m_ack_o, 2'b00);
                check("miss_err", {m_err_o, bus_err}, (c == 2) ? {mbit, 1'b1} : 3'b000);
                if (c == 2) break;
            end
        end
        @(negedge clk);
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
        s_ack_i    = '0;
        #1;
        check("err_once", m_err_o, 2'b00);
        if (es < 0) check("err_adr", err_adr, adr);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          owner, exp_m, drop_m, reraise_m, n_done, idle_run;
        int          grants [N_M];
        int          err_seen;
        logic        exp_err;
        logic [31:0] a0, a1;

        rst = 1'b0;
        m_dat_i = '0; m_adr_i = '0; m_sel_i = '0; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0; s_dat_i = '0; s_ack_i = '0;
        #12;
        check("rst_outs", {m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_sel_o, s_we_o,
                           s_cyc_o, s_stb_o, bus_err, err_adr}, '0);
        check("rst_outs_nt", {nt_m_ack_o, nt_m_err_o, nt_s_cyc_o, nt_s_stb_o, nt_bus_err}, '0);
        @(negedge clk);
        rst = 1'b1;

        // First read after reset goes to master 0, slave 1.
        run_xfer(0, 32'h4000_0004, 1, 1'b0, 32'hA5A5_A5A5);

        // Unmapped address from master 1.
        run_xfer(1, 32'h2000_0000, 1, 1'b0, 32'h0);

        // Watchdog: slave 2 never acks; errors every TMO+1 cycles, none without watchdog.
        @(negedge clk);
        m_adr_i[31:0] = 32'h6000_0000;
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        model_last = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            s_ack_i = '0;
            #1;
            exp_err = (c % (TMO + 1) == 0);
            check("tmo_err", {m_err_o, bus_err}, exp_err ? 3'b011 : 3'b000);
            check("tmo_stb", s_stb_o, exp_err ? 7'd0 : slave_oh(2));
            check("nt_no_err", {nt_m_err_o, nt_bus_err}, 3'b000);
            check("nt_stb", nt_s_stb_o, slave_oh(2));
            if (c == TMO + 2) check("tmo_err_adr", err_adr, 32'h6000_0000);
        end
        @(negedge clk);
        m_cyc_i = '0;
        m_stb_i = '0;
        @(negedge clk);
        @(negedge clk);

        // Ack arriving in the very cycle the watchdog would fire wins.
        @(negedge clk);
        m_adr_i[31:0] = 32'h6000_0004;
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        for (int c = 1; c <= TMO + 1; c++) begin
            @(negedge clk);
            if (c == TMO + 1) begin
                s_ack_i = slave_oh(2);
                s_dat_i[64 +: 32] = 32'h5A5A_1234;
            end
            #1;
            if (c == TMO + 1) begin
                check("race_ack", m_ack_o, 2'b01);
                check("race_err", {m_err_o, bus_err}, 3'b000);
                check("race_dat", m_dat_o, 32'h5A5A_1234);
                check("race_stb", s_stb_o, slave_oh(2));
            end
        end
        @(negedge clk);
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        #1;
        check("race_after", m_err_o, 2'b00);
        @(negedge clk);
        @(negedge clk);

        // Randomized single-master transfers with unselected-slave ack noise.
        for (int t = 0; t < 24; t++) begin
            run_xfer(int'($urandom_range(0, 1)), 32'($urandom), int'($urandom_range(1, 4)),
                     1'b1, 32'($urandom));
        end

        // Both masters request continuously; single-cycle transfers.
        a0 = 32'h4000_0000;
        a1 = 32'h6000_0000;
        @(negedge clk);
        m_adr_i = {a1, a0};
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        drop_m = -1;
        reraise_m = -1;
        n_done = 0;
        idle_run = 0;
        grants[0] = 0;
        grants[1] = 0;
        for (int c = 0; c < 300 && n_done < 20; c++) begin
            @(negedge clk);
            s_ack_i = '0;
            if (reraise_m >= 0) begin
                m_cyc_i[reraise_m] = 1'b1;
                m_stb_i[reraise_m] = 1'b1;
                reraise_m = -1;
            end
            if (drop_m >= 0) begin
                m_cyc_i[drop_m] = 1'b0;
                m_stb_i[drop_m] = 1'b0;
                reraise_m = drop_m;
                drop_m = -1;
            end
            #1;
            if (s_stb_o != 7'd0) begin
                exp_m = rr_pick(model_last, 2'b11);
                owner = (s_adr_o == a0) ? 0 : (s_adr_o == a1) ? 1 : -1;
                check("rr_owner", owner, exp_m);
                check("rr_stb", s_stb_o, slave_oh(ref_decode(exp_m == 0 ? a0 : a1)));
                if (n_done > 0) check("rr_gap", idle_run >= 1, 1'b1);
                s_ack_i = s_stb_o;
                #1;
                check("rr_ack", m_ack_o, 2'd1 << exp_m);
                model_last = exp_m;
                if (owner >= 0) grants[owner]++;
                drop_m = (owner >= 0) ? owner : exp_m;
                n_done++;
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
        check("rr_done", n_done, 20);
        check("rr_fair", {grants[0], grants[1]}, {32'd10, 32'd10});
        @(negedge clk);
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a master-1 transfer, then a simultaneous request.
        @(negedge clk);
        m_adr_i[63:32] = 32'h8000_0000;
        m_cyc_i = 2'b10;
        m_stb_i = 2'b10;
        @(negedge clk);
        #1;
        check("mid_stb", s_stb_o, slave_oh(ref_decode(32'h8000_0000)));
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_sel_o, s_we_o,
                               s_cyc_o, s_stb_o, bus_err, err_adr}, '0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_hold", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, '0);
        m_adr_i[31:0] = 32'h4000_0010;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        err_seen = 0;
        s_ack_i = slave_oh(1);
        #1;
        check("post_rst_adr", s_adr_o, 32'h4000_0010);
        check("post_rst_stb", s_stb_o, slave_oh(1));
        check("post_rst_ack", m_ack_o, 2'b01);
        @(negedge clk);
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = '0;
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
